agree_predictor_v3: RTL and testbench

Parametrised successor to the direct-mapped agree predictor. Sits in the IF stage and is updated from the branch commit stage (EXMEM).
- BTB is WAYS-way set-associative with per-set round-robin replacement and a per-entry agree/bias bit.
- PHT holds CTR_WIDTH-bit saturating agree counters, gshare-indexed.
- Speculative GHR, repaired on mispredict.
- Reset-sweep init FSM clears all tables before predictions are enabled.

---
 rtl/agree_predictor_v3.sv | 233 +++++++++++++++++++++++
 tb/tb_agree_predictor_v3.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/agree_predictor_v3.sv
// Agree branch predictor: set-associative BTB with per-entry bias, gshare-indexed
// agree-counter PHT, speculative GHR with commit-time repair, reset-sweep table init.
`timescale 1ns/1ps
module agree_predictor_v3 #(
  parameter int SET_BITS      = 4,
  parameter int WAYS          = 2,
  parameter int HISTORY_WIDTH = 8,
  parameter int CTR_WIDTH     = 2,
  localparam int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              IF_pc_i,
  input  logic                     IF_stall_i,
  output logic                     IF_hit_o,
  output logic [WAY_W-1:0]         IF_way_o,
  output logic                     IF_prediction_o,
  output logic                     IF_bias_o,
  output logic [31:0]              IF_target_o,
  output logic [HISTORY_WIDTH-1:0] IF_ghr_o,
  output logic [1:0]               IF_PCnext_sel_o,
  output logic                     IF_flush_o,
  output logic                     init_done_o,
  input  logic                     EXMEM_valid_i,
  input  logic [31:0]              EXMEM_pc_i,
  input  logic [31:0]              EXMEM_target_i,
  input  logic                     EXMEM_is_br_i,
  input  logic                     EXMEM_is_jalr_i,
  input  logic                     EXMEM_taken_i,
  input  logic                     EXMEM_prediction_i,
  input  logic                     EXMEM_hit_i,
  input  logic [WAY_W-1:0]         EXMEM_way_i,
  input  logic                     EXMEM_bias_i,
  input  logic [HISTORY_WIDTH-1:0] EXMEM_ghr_i
);

  localparam int SETS       = 1 << SET_BITS;
  localparam int PHT_N      = 1 << HISTORY_WIDTH;
  localparam int SWEEP_BITS = (SET_BITS > HISTORY_WIDTH) ? SET_BITS : HISTORY_WIDTH;
  localparam int TAG_W      = 30 - SET_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_ZERO = {CTR_WIDTH{1'b0}};
  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_EX_PC4 = 2'b01;
  localparam logic [1:0] SEL_TGT    = 2'b10;
  localparam logic [1:0] SEL_EX_TGT = 2'b11;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                   state_r, state_nx_s;
  logic [SWEEP_BITS-1:0]    sweep_r;
  logic [HISTORY_WIDTH-1:0] ghr_r;

  logic                     valid_r  [SETS][WAYS];
  logic [TAG_W-1:0]         tag_r    [SETS][WAYS];
  logic [31:0]              target_r [SETS][WAYS];
  logic                     bias_r   [SETS][WAYS];
  logic [WAY_W-1:0]         rr_r     [SETS];
  logic [CTR_WIDTH-1:0]     pht_r    [PHT_N];

  logic                     ready_s, sweep_we_s, sweep_last_s, sweep_set_ok_s, sweep_pht_ok_s;
  logic [SET_BITS-1:0]      sweep_set_s, if_set_s, ex_set_s;
  logic [HISTORY_WIDTH-1:0] sweep_pht_s, if_pht_idx_s, ex_pht_idx_s;
  logic [TAG_W-1:0]         if_tag_s, ex_tag_s;
  logic                     hit_s, hit_bias_s, pred_s;
  logic [WAY_W-1:0]         way_s, alloc_way_s, rr_nx_s;
  logic [31:0]              hit_target_s;
  logic                     commit_s, mispredict_s, jalr_taken_s, alloc_s, retarget_s, pht_upd_s;
  logic [CTR_WIDTH-1:0]     ctr_cur_s, ctr_nx_s;
  logic [1:0]               sel_s;
  logic                     flush_s;
  logic                     unused_s;

  assign unused_s = ^{IF_pc_i[1:0], EXMEM_pc_i[1:0]};

  assign sweep_last_s   = &sweep_r;
  assign sweep_we_s     = !rst_i && (state_r == ST_INIT);
  assign sweep_set_s    = sweep_r[SET_BITS-1:0];
  assign sweep_pht_s    = sweep_r[HISTORY_WIDTH-1:0];
  assign sweep_set_ok_s = int'(sweep_r) < SETS;
  assign sweep_pht_ok_s = int'(sweep_r) < PHT_N;

  assign if_set_s     = IF_pc_i[SET_BITS+1:2];
  assign if_tag_s     = IF_pc_i[31:SET_BITS+2];
  assign if_pht_idx_s = IF_pc_i[HISTORY_WIDTH+1:2] ^ ghr_r;
  assign ex_set_s     = EXMEM_pc_i[SET_BITS+1:2];
  assign ex_tag_s     = EXMEM_pc_i[31:SET_BITS+2];
  assign ex_pht_idx_s = EXMEM_pc_i[HISTORY_WIDTH+1:2] ^ EXMEM_ghr_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_r <= ST_INIT;
    else       state_r <= state_nx_s;
  end

  // FSM next state: leave INIT after the last sweep index
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_INIT:  if (sweep_last_s) state_nx_s = ST_READY; else state_nx_s = ST_INIT;
      ST_READY: state_nx_s = ST_READY;
      default:  state_nx_s = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_INIT:  ready_s = 1'b0;
      ST_READY: ready_s = 1'b1;
      default:  ready_s = 1'b0;
    endcase
  end

  assign init_done_o = ready_s;

  // Sweep index, advancing one entry per INIT cycle
  always_ff @(posedge clk_i) begin
    if (rst_i)                     sweep_r <= {SWEEP_BITS{1'b0}};
    else if (state_r == ST_INIT)   sweep_r <= sweep_r + SWEEP_BITS'(1);
    else                           sweep_r <= sweep_r;
  end

  // BTB lookup; scanning downward lets the lowest matching way win
  always_comb begin
    hit_s = 1'b0;
    way_s = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_r[if_set_s][w] && (tag_r[if_set_s][w] == if_tag_s)) begin
        hit_s = 1'b1;
        way_s = WAY_W'(w);
      end else begin
        hit_s = hit_s;
        way_s = way_s;
      end
    end
  end

  assign hit_bias_s   = bias_r[if_set_s][way_s];
  assign hit_target_s = target_r[if_set_s][way_s];
  assign pred_s       = hit_s & ~(pht_r[if_pht_idx_s][CTR_WIDTH-1] ^ hit_bias_s);

  // Fetch-side outputs, forced quiet until the tables are initialised
  always_comb begin
    IF_hit_o        = 1'b0;
    IF_way_o        = {WAY_W{1'b0}};
    IF_prediction_o = 1'b0;
    IF_bias_o       = 1'b0;
    IF_target_o     = 32'h0000_0000;
    IF_ghr_o        = {HISTORY_WIDTH{1'b0}};
    if (ready_s && hit_s) begin
      IF_hit_o        = 1'b1;
      IF_way_o        = way_s;
      IF_prediction_o = pred_s;
      IF_bias_o       = hit_bias_s;
      IF_target_o     = hit_target_s;
      IF_ghr_o        = ghr_r;
    end else if (ready_s) begin
      IF_ghr_o        = ghr_r;
    end else begin
      IF_ghr_o        = {HISTORY_WIDTH{1'b0}};
    end
  end

  assign commit_s     = !rst_i && ready_s && EXMEM_valid_i;
  assign mispredict_s = commit_s && EXMEM_is_br_i && (EXMEM_prediction_i != EXMEM_taken_i);
  assign jalr_taken_s = commit_s && EXMEM_is_jalr_i && EXMEM_taken_i;
  assign alloc_s      = commit_s && EXMEM_is_br_i && !EXMEM_hit_i;
  assign retarget_s   = commit_s && EXMEM_hit_i && EXMEM_taken_i;
  assign pht_upd_s    = commit_s && EXMEM_is_br_i;
  assign alloc_way_s  = rr_r[ex_set_s];
  assign rr_nx_s      = (alloc_way_s == WAY_W'(WAYS - 1)) ? {WAY_W{1'b0}} : alloc_way_s + WAY_W'(1);
  assign ctr_cur_s    = pht_r[ex_pht_idx_s];

  // Agree counter: count toward "agree" when the outcome matches the bias
  always_comb begin
    ctr_nx_s = ctr_cur_s;
    if (EXMEM_taken_i == EXMEM_bias_i) ctr_nx_s = (ctr_cur_s == CTR_MAX)  ? ctr_cur_s : ctr_cur_s + CTR_WIDTH'(1);
    else                               ctr_nx_s = (ctr_cur_s == CTR_ZERO) ? ctr_cur_s : ctr_cur_s - CTR_WIDTH'(1);
  end

  // Next-PC select and flush
  always_comb begin
    sel_s   = SEL_PC4;
    flush_s = 1'b0;
    if (!ready_s) begin
      sel_s = SEL_PC4;   flush_s = 1'b0;
    end else if (mispredict_s && EXMEM_prediction_i) begin
      sel_s = SEL_EX_PC4; flush_s = 1'b1;
    end else if (mispredict_s || jalr_taken_s) begin
      sel_s = SEL_EX_TGT; flush_s = 1'b1;
    end else begin
      sel_s = pred_s ? SEL_TGT : SEL_PC4; flush_s = 1'b0;
    end
  end

  assign IF_PCnext_sel_o = sel_s;
  assign IF_flush_o      = flush_s;

  // GHR: commit repair outranks the speculative shift
  always_ff @(posedge clk_i) begin
    if (rst_i || state_r == ST_INIT) ghr_r <= {HISTORY_WIDTH{1'b0}};
    else if (mispredict_s)           ghr_r <= {EXMEM_ghr_i[HISTORY_WIDTH-2:0], EXMEM_taken_i};
    else if (jalr_taken_s)           ghr_r <= EXMEM_ghr_i;
    else if (hit_s && !IF_stall_i)   ghr_r <= {ghr_r[HISTORY_WIDTH-2:0], pred_s};
    else                             ghr_r <= ghr_r;
  end

  // BTB storage: sweep clear, allocate, or retarget
  always_ff @(posedge clk_i) begin
    if (sweep_we_s && sweep_set_ok_s) begin
      for (int w = 0; w < WAYS; w++) valid_r[sweep_set_s][w] <= 1'b0;
      rr_r[sweep_set_s] <= {WAY_W{1'b0}};
    end else if (alloc_s) begin
      valid_r[ex_set_s][alloc_way_s]  <= 1'b1;
      tag_r[ex_set_s][alloc_way_s]    <= ex_tag_s;
      target_r[ex_set_s][alloc_way_s] <= EXMEM_target_i;
      bias_r[ex_set_s][alloc_way_s]   <= EXMEM_taken_i;
      rr_r[ex_set_s]                  <= rr_nx_s;
    end else if (retarget_s) begin
      target_r[ex_set_s][EXMEM_way_i] <= EXMEM_target_i;
    end
  end

  // PHT storage: sweep to weak agree, then saturating commit updates
  always_ff @(posedge clk_i) begin
    if (sweep_we_s && sweep_pht_ok_s) pht_r[sweep_pht_s]  <= CTR_INIT;
    else if (pht_upd_s)               pht_r[ex_pht_idx_s] <= ctr_nx_s;
  end

endmodule

// File: tb/tb_agree_predictor_v3.sv
// Scoreboard bench for agree_predictor_v3: expected fetch-side outputs are queued
// as stimulus is driven and popped when the outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_agree_predictor_v3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_stall;
  logic [31:0] if_pc;
  logic        if_hit, if_pred, if_bias, if_flush, init_done;
  logic [0:0]  if_way;
  logic [31:0] if_target;
  logic [7:0]  if_ghr;
  logic [1:0]  if_sel;
  logic        ex_valid, ex_br, ex_jalr, ex_taken, ex_pred, ex_hit, ex_bias;
  logic [31:0] ex_pc, ex_target;
  logic [0:0]  ex_way;
  logic [7:0]  ex_ghr;

  agree_predictor_v3 dut (
    .clk_i(clk), .rst_i(rst), .IF_pc_i(if_pc), .IF_stall_i(if_stall),
    .IF_hit_o(if_hit), .IF_way_o(if_way), .IF_prediction_o(if_pred), .IF_bias_o(if_bias),
    .IF_target_o(if_target), .IF_ghr_o(if_ghr), .IF_PCnext_sel_o(if_sel), .IF_flush_o(if_flush),
    .init_done_o(init_done), .EXMEM_valid_i(ex_valid), .EXMEM_pc_i(ex_pc),
    .EXMEM_target_i(ex_target), .EXMEM_is_br_i(ex_br), .EXMEM_is_jalr_i(ex_jalr),
    .EXMEM_taken_i(ex_taken), .EXMEM_prediction_i(ex_pred), .EXMEM_hit_i(ex_hit),
    .EXMEM_way_i(ex_way), .EXMEM_bias_i(ex_bias), .EXMEM_ghr_i(ex_ghr)
  );

  // fields: hit, way, pred, bias, target, ghr, sel, flush, done
  typedef struct packed {
    logic hit; logic [0:0] way; logic pred; logic bias; logic [31:0] tgt;
    logic [7:0] ghr; logic [1:0] sel; logic flush; logic done;
  } obs_t;

  obs_t obs_s;
  assign obs_s = {if_hit, if_way, if_pred, if_bias, if_target, if_ghr, if_sel, if_flush, init_done};

  obs_t exp_q[$];
  obs_t got, want;
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic obs_t mk(input logic hit, input logic way, input logic pred, input logic bias,
                              input logic [31:0] tgt, input logic [7:0] ghr, input logic [1:0] sel,
                              input logic flush, input logic done);
    return {hit, way, pred, bias, tgt, ghr, sel, flush, done};
  endfunction

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic br, input logic jalr, input logic taken, input logic pred,
                          input logic hit, input logic way, input logic bias, input logic [7:0] ghr);
    ex_valid = v; ex_pc = pc; ex_target = tgt; ex_br = br; ex_jalr = jalr; ex_taken = taken;
    ex_pred = pred; ex_hit = hit; ex_way = way; ex_bias = bias; ex_ghr = ghr;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1; if_stall = 1'b0; if_pc = 32'h0; idle_ex();
    repeat (2) begin @(posedge clk); #1; end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 2'b00, 1'b0, 1'b0));
    @(negedge clk); got = obs_s; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL reset_state: got %h want %h", got, want); end
    rst = 1'b0;
    // partial sweep, reset again, then a full sweep with commits that must be ignored
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < ((ph == 0) ? 100 : 256); i++) begin
        if_pc = $urandom;
        drive_ex(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 2'b00, 1'b0, 1'b0));
        @(negedge clk); got = obs_s; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_fail++; $display("FAIL init_sweep ph%0d cyc%0d: got %h want %h", ph, i, got, want); end
        @(posedge clk); #1;
      end
      if (ph == 0) begin rst = 1'b1; @(posedge clk); #1; rst = 1'b0; end
    end
    idle_ex(); if_pc = 32'h0000_03F0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 2'b00, 1'b0, 1'b1));
    @(negedge clk); got = obs_s; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL init_done: got %h want %h", got, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_alloc_hit_stall();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin if_pc = 32'h100; if_stall = 1'b0;
             drive_ex(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 2'b11, 1'b1, 1'b1)); end
        1: begin idle_ex(); if_stall = 1'b1;
             exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 8'h01, 2'b10, 1'b0, 1'b1)); end
        2: begin if_stall = 1'b0;
             exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 8'h01, 2'b10, 1'b0, 1'b1)); end
        default: begin if_pc = 32'h000;
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h03, 2'b00, 1'b0, 1'b1)); end
      endcase
      @(negedge clk); got = obs_s; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL alloc_hit_stall step %0d: got %h want %h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    if_stall = 1'b1;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin if_pc = 32'h3F0;
             drive_ex(1'b1, 32'h800, 32'h900, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h03, 2'b11, 1'b1, 1'b1)); end
        1, 2, 3: begin
             drive_ex(1'b1, 32'h014 + 32'(c - 1) * 32'h40, 32'h1000 * 32'(c), 1'b1, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0, 8'h00);
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 2'b00, 1'b0, 1'b1)); end
        4: begin idle_ex(); if_pc = 32'h014;
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 2'b00, 1'b0, 1'b1)); end
        5: begin if_pc = 32'h054;
             exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 8'h00, 2'b00, 1'b0, 1'b1)); end
        default: begin if_pc = 32'h094;
             exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 8'h00, 2'b00, 1'b0, 1'b1)); end
      endcase
      @(negedge clk); got = obs_s; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL round_robin step %0d: got %h want %h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pht_saturate();
    if_stall = 1'b1;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: begin if_pc = 32'h3F0;
             drive_ex(1'b1, 32'h10C, 32'h400, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 2'b11, 1'b1, 1'b1)); end
        1, 4: begin if_pc = 32'h3F0;
             drive_ex(1'b1, 32'h800, 32'h900, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10);
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, (c == 1) ? 8'h01 : 8'h20, 2'b11, 1'b1, 1'b1)); end
        2: begin if_pc = 32'h10C; idle_ex();
             exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 8'h10, 2'b10, 1'b0, 1'b1)); end
        3: begin if_pc = 32'h10C;
             drive_ex(1'b1, 32'h10C, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
             exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 8'h10, 2'b01, 1'b1, 1'b1)); end
        6, 7: begin if_pc = 32'h10C;
             drive_ex(1'b1, 32'h10C, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
             exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 8'h10, 2'b00, 1'b0, 1'b1)); end
        default: begin if_pc = 32'h10C; idle_ex();
             exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 8'h10, 2'b00, 1'b0, 1'b1)); end
      endcase
      @(negedge clk); got = obs_s; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL pht_saturate step %0d: got %h want %h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mispredict_repair();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin if_pc = 32'h100; if_stall = 1'b0;
             drive_ex(1'b1, 32'h10C, 32'h400, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
             exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 8'h10, 2'b11, 1'b1, 1'b1)); end
        1: begin if_pc = 32'h3F0; if_stall = 1'b1; idle_ex();
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h4B, 2'b00, 1'b0, 1'b1)); end
        default: begin if_pc = 32'h100;
             drive_ex(1'b1, 32'h800, 32'h900, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
             exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 8'h4B, 2'b10, 1'b0, 1'b1)); end
      endcase
      @(negedge clk); got = obs_s; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL mispredict_repair step %0d: got %h want %h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alloc_hit_stall();
    test_round_robin();
    test_pht_saturate();
    test_mispredict_repair();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
